btn_debounce_multi: RTL and testbench
=====================================

Name: btn_debounce_multi

Overview:
- Parametrised multi-channel push-button conditioner; next generation of the board-level chattering filter.
- Synchronises NCH raw button inputs and samples them on a shared prescaled tick.
- Requires STABLE consecutive agreeing samples before accepting a level change.
- Outputs a clean level, one-cycle press and release pulses per channel, and optional auto-repeat; sits between board pins and FSM/CPU control logic.

Parameters:
- NCH, 2, number of independent button channels (>=1).
- DIV, 1250000, system clocks per sample tick (>=2); 40 Hz at 50 MHz.
- STABLE, 2, consecutive differing samples required to accept a new level (>=1).
- ACTIVE_LOW, 1, 1 = BIN reads 0 when pressed; 0 = BIN reads 1 when pressed.
- REP_DELAY, 20, ticks from accepted press to first auto-repeat pulse (>=1; used only with AUTO_REPEAT_EN).
- REP_RATE, 4, ticks between subsequent repeat pulses (>=1; used only with AUTO_REPEAT_EN).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  synchronous, active-low reset.
- BIN  in  NCH  raw asynchronous button inputs.
- LEVEL  out  NCH  debounced state; 1 = pressed.
- PRESS  out  NCH  one-CLK pulse on accepted press (and on repeats, if enabled).
- RELEASE  out  NCH  one-CLK pulse on accepted release.
- TICK  out  1  one-CLK sample strobe, for system use.

Behaviour:
- Reset: one clock, synchronous, active-low. On any CLK edge with nRST=0:
  - LEVEL, PRESS, RELEASE and TICK go to 0.
  - Prescaler and all per-channel counters clear.
  - Synchroniser FFs load the released value (all 1 if ACTIVE_LOW, else all 0), so no spurious event occurs after reset.
- Reset mid-operation discards partial stability counts and repeat timing. A button held through reset needs STABLE fresh ticks after release of nRST before PRESS fires.
- Prescaler: counter of width clog2(DIV). It counts 0..DIV-1; tick = (cnt==DIV-1), and it wraps to 0 on tick. The TICK output is the registered tick, so it is high for 1 cycle every DIV cycles.
- Synchroniser: two FFs per channel, clocked every CLK. The synchronised value is normalised to "pressed=1" using ACTIVE_LOW.
- Per-channel filter, evaluated only when tick=1:
  - If the sample equals LEVEL: the agreement counter clears.
  - Otherwise the counter increments. On reaching STABLE, LEVEL toggles and the counter clears in the same edge.
  - The counter saturates at STABLE and never wraps; its width is clog2(STABLE+1).
- Events: PRESS (RELEASE) is registered high for exactly the one cycle after the edge where LEVEL goes 0->1 (1->0). That cycle coincides with the first cycle of the new LEVEL value.
- Latency: worst-case from a clean BIN change to the LEVEL change is 2 + STABLE*DIV cycles.
- Channels are fully independent. Simultaneous events on several channels pulse in the same cycle.
- A pulse on BIN shorter than STABLE ticks never changes LEVEL.
- STABLE=1 accepts a change on the first differing tick.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined:
  - A per-channel repeat counter runs while LEVEL=1. It clears on the accepted press and counts ticks.
  - After REP_DELAY ticks, PRESS pulses again for one cycle; after that it pulses every REP_RATE ticks.
  - Release or reset stops repeats and clears the counter.
  - RELEASE is unaffected.
- Undefined: no repeat logic is built; REP_DELAY and REP_RATE are ignored; PRESS fires once per accepted press.

Test Plan (bench parameters: NCH=2, DIV=4, STABLE=3, ACTIVE_LOW=1):
- Reset: hold BIN=2'b00 (pressed) with nRST=0 for 5 cycles, then release nRST -> all outputs 0 during reset; PRESS[1:0]=2'b11 pulses once at the 3rd tick after reset; LEVEL=2'b11 from that cycle.
- Clean press/release on ch0: drive BIN[0]=0 for 40 cycles -> one PRESS[0] pulse <= 2+12 cycles after the drop; LEVEL[0]=1; ch1 silent. Then drive BIN[0]=1 -> one RELEASE[0] pulse after 3 ticks; LEVEL[0]=0.
- Bounce rejection: toggle BIN[0] every 5 cycles for 60 cycles -> LEVEL[0] stays 0; no PRESS/RELEASE. Then hold BIN[0] low -> a single PRESS[0].
- Simultaneous channels: drop BIN=2'b11->2'b00 on the same edge -> PRESS=2'b11 in the same cycle; check the TICK period is exactly 4 cycles.
- Reset mid-count: after 2 agreeing ticks on ch0, pulse nRST=0 for 1 cycle -> no PRESS; PRESS[0] arrives only after 3 further ticks.
- AUTO_REPEAT_EN with REP_DELAY=5, REP_RATE=2: hold ch0 pressed for 100 cycles -> PRESS[0] pulses at accept, accept+5 ticks, then every 2 ticks; none after RELEASE[0]. Without the macro: exactly one PRESS[0].

Source files
------------

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: multi-channel push-button conditioner.
// Raw button pins are double-flop synchronised and sampled on a shared
// prescaled tick. A level change is accepted only after STABLE consecutive
// ticks disagree with the current debounced level. Outputs are the clean
// level plus one-cycle press/release pulses per channel and the sample strobe.
// Optional build macro: AUTO_REPEAT_EN adds per-channel auto-repeat on PRESS
// (first repeat REP_DELAY ticks after the press, then every REP_RATE ticks).
module btn_debounce_multi #(
  parameter int NCH        = 2,
  parameter int DIV        = 1250000,
  parameter int STABLE     = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int REP_DELAY  = 20,
  parameter int REP_RATE   = 4
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic [NCH-1:0] BIN,
  output logic [NCH-1:0] LEVEL,
  output logic [NCH-1:0] PRESS,
  output logic [NCH-1:0] RELEASE,
  output logic           TICK
);

  localparam int              CW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int              SW         = $clog2(STABLE + 1);
  localparam logic [CW-1:0]   DIV_LAST   = CW'(DIV - 1);
  localparam logic [SW-1:0]   STABLE_C   = SW'(STABLE);
  localparam logic [NCH-1:0]  RELEASED_C = (ACTIVE_LOW != 0) ? {NCH{1'b1}} : {NCH{1'b0}};

  logic [CW-1:0]  div_cnt_r;
  logic           tick_s;
  logic [NCH-1:0] sync1_r;
  logic [NCH-1:0] sync2_r;
  logic [NCH-1:0] sample_s;
  logic [SW-1:0]  stab_r     [NCH];
  logic [SW-1:0]  stab_nxt_s [NCH];
  logic [NCH-1:0] level_nxt_s;
  logic [NCH-1:0] press_s;
  logic [NCH-1:0] release_s;
  logic [NCH-1:0] rep_pulse_s;

  // Sample strobe fires on the last count of each DIV-cycle period.
  assign tick_s   = (div_cnt_r == DIV_LAST);
  // Normalise the synchronised pins so that 1 always means pressed.
  assign sample_s = (ACTIVE_LOW != 0) ? ~sync2_r : sync2_r;

  // Prescaler: counts 0..DIV-1, wraps on tick; TICK is the registered strobe.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      div_cnt_r <= {CW{1'b0}};
      TICK      <= 1'b0;
    end else begin
      if (tick_s) begin
        div_cnt_r <= {CW{1'b0}};
      end else begin
        div_cnt_r <= div_cnt_r + CW'(1'b1);
      end
      TICK <= tick_s;
    end
  end

  // Two-flop synchroniser; reset loads the released level so no event follows reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sync1_r <= RELEASED_C;
      sync2_r <= RELEASED_C;
    end else begin
      sync1_r <= BIN;
      sync2_r <= sync1_r;
    end
  end

  // Per-channel agreement filter: count disagreeing ticks, toggle level at STABLE.
  always_comb begin
    level_nxt_s = LEVEL;
    for (int i = 0; i < NCH; i++) begin
      stab_nxt_s[i] = stab_r[i];
      if (tick_s) begin
        if (sample_s[i] == LEVEL[i]) begin
          stab_nxt_s[i] = {SW{1'b0}};
        end else if ((stab_r[i] + SW'(1'b1)) >= STABLE_C) begin
          level_nxt_s[i] = ~LEVEL[i];
          stab_nxt_s[i]  = {SW{1'b0}};
        end else begin
          stab_nxt_s[i] = stab_r[i] + SW'(1'b1);
        end
      end else begin
        stab_nxt_s[i] = stab_r[i];
      end
    end
    press_s   = level_nxt_s & ~LEVEL;
    release_s = ~level_nxt_s & LEVEL;
  end

`ifdef AUTO_REPEAT_EN
  localparam int            RMAX        = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int            RW          = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_DELAY_C = RW'(REP_DELAY);
  localparam logic [RW-1:0] REP_RATE_C  = RW'(REP_RATE);

  logic [RW-1:0]  rep_cnt_r       [NCH];
  logic [RW-1:0]  rep_cnt_nxt_s   [NCH];
  logic [NCH-1:0] rep_phase_r;
  logic [NCH-1:0] rep_phase_nxt_s;

  // Repeat timing: first period is REP_DELAY ticks, later periods REP_RATE ticks.
  always_comb begin
    rep_pulse_s     = {NCH{1'b0}};
    rep_phase_nxt_s = rep_phase_r;
    for (int i = 0; i < NCH; i++) begin
      rep_cnt_nxt_s[i] = rep_cnt_r[i];
      if (!level_nxt_s[i] || press_s[i]) begin
        rep_cnt_nxt_s[i]   = {RW{1'b0}};
        rep_phase_nxt_s[i] = 1'b0;
      end else if (tick_s) begin
        if ((rep_cnt_r[i] + RW'(1'b1)) == (rep_phase_r[i] ? REP_RATE_C : REP_DELAY_C)) begin
          rep_pulse_s[i]     = 1'b1;
          rep_cnt_nxt_s[i]   = {RW{1'b0}};
          rep_phase_nxt_s[i] = 1'b1;
        end else begin
          rep_cnt_nxt_s[i] = rep_cnt_r[i] + RW'(1'b1);
        end
      end else begin
        rep_cnt_nxt_s[i] = rep_cnt_r[i];
      end
    end
  end

  // Repeat counter registers; cleared by reset so repeats restart from scratch.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rep_phase_r <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        rep_cnt_r[i] <= {RW{1'b0}};
      end
    end else begin
      rep_phase_r <= rep_phase_nxt_s;
      for (int i = 0; i < NCH; i++) begin
        rep_cnt_r[i] <= rep_cnt_nxt_s[i];
      end
    end
  end
`else
  assign rep_pulse_s = {NCH{1'b0}};
`endif

  // Filter state and registered level/event outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      LEVEL   <= {NCH{1'b0}};
      PRESS   <= {NCH{1'b0}};
      RELEASE <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        stab_r[i] <= {SW{1'b0}};
      end
    end else begin
      LEVEL   <= level_nxt_s;
      PRESS   <= press_s | rep_pulse_s;
      RELEASE <= release_s;
      for (int i = 0; i < NCH; i++) begin
        stab_r[i] <= stab_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Self-checking bench for btn_debounce_multi (NCH=2, DIV=4, STABLE=3,
// ACTIVE_LOW=1, REP_DELAY=5, REP_RATE=2). A tick-indexed reference model
// predicts LEVEL/PRESS/RELEASE/TICK every cycle; directed steps add
// event-count and timing checks. Honours AUTO_REPEAT_EN like the design.
module tb_btn_debounce_multi;

  localparam int NCH       = 2;
  localparam int DIV       = 4;
  localparam int STABLE    = 3;
  localparam int REP_DELAY = 5;
  localparam int REP_RATE  = 2;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [1:0] BIN;
  logic [1:0] LEVEL;
  logic [1:0] PRESS;
  logic [1:0] RELEASE;
  logic       TICK;

  btn_debounce_multi #(
    .NCH(NCH), .DIV(DIV), .STABLE(STABLE), .ACTIVE_LOW(1),
    .REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)
  ) dut (
    .CLK(CLK), .nRST(nRST), .BIN(BIN),
    .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit [1:0] dq[$];
  int       n_edges;
  int       tk;
  int       last_blk [2];
  int       press_tk [2];
  bit [1:0] m_level;
  bit [1:0] m_press;
  bit [1:0] m_release;
  bit       m_tick;

  // per-phase observation counters
  int dut_pc [2];
  int dut_rc [2];
  int mod_pc [2];
  int cyc;
  int first_press;
  bit both_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: pins reach the filter two edges late; a level flips once the
  // last STABLE tick samples since the last agreement/flip all disagree.
  function automatic void model_edge(input bit rst_n, input bit [1:0] bin);
    bit [1:0] s;
    bit       changed;
    int       d;
    if (!rst_n) begin
      dq.delete();
      dq.push_back(2'b00);
      dq.push_back(2'b00);
      n_edges   = 0;
      tk        = 0;
      last_blk  = '{0, 0};
      press_tk  = '{0, 0};
      m_level   = 2'b00;
      m_press   = 2'b00;
      m_release = 2'b00;
      m_tick    = 1'b0;
    end else begin
      s = dq.pop_front();
      dq.push_back(~bin);
      m_tick    = ((n_edges % DIV) == DIV - 1);
      n_edges++;
      m_press   = 2'b00;
      m_release = 2'b00;
      if (m_tick) begin
        tk++;
        for (int ch = 0; ch < 2; ch++) begin
          changed = 1'b0;
          if (s[ch] == m_level[ch]) begin
            last_blk[ch] = tk;
          end else if (tk - last_blk[ch] >= STABLE) begin
            changed      = 1'b1;
            m_level[ch]  = ~m_level[ch];
            last_blk[ch] = tk;
            if (m_level[ch]) begin
              m_press[ch]  = 1'b1;
              press_tk[ch] = tk;
            end else begin
              m_release[ch] = 1'b1;
            end
          end
`ifdef AUTO_REPEAT_EN
          if (!changed && m_level[ch]) begin
            d = tk - press_tk[ch];
            if (d == REP_DELAY || (d > REP_DELAY && ((d - REP_DELAY) % REP_RATE) == 0))
              m_press[ch] = 1'b1;
          end
`endif
        end
      end
    end
  endfunction

  task automatic clr();
    dut_pc      = '{0, 0};
    dut_rc      = '{0, 0};
    mod_pc      = '{0, 0};
    cyc         = 0;
    first_press = -1;
    both_seen   = 1'b0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge(nRST, BIN);
    #1;
    cyc++;
    chk("level", LEVEL, m_level);
    chk("press", PRESS, m_press);
    chk("release", RELEASE, m_release);
    chk("tick", TICK, m_tick);
    for (int ch = 0; ch < 2; ch++) begin
      dut_pc[ch] += int'(PRESS[ch]);
      dut_rc[ch] += int'(RELEASE[ch]);
      mod_pc[ch] += int'(m_press[ch]);
    end
    if (PRESS != 2'b00 && first_press < 0) first_press = cyc;
    if (PRESS === 2'b11) both_seen = 1'b1;
  endtask

  task automatic run(input int k);
    repeat (k) cycle();
  endtask

  initial begin
    int k;
    int p;
    clr();
    // reset held with both buttons pressed
    nRST = 1'b0;
    BIN  = 2'b00;
    run(5);
    chk("rst_outputs", {LEVEL, PRESS, RELEASE, TICK}, 7'd0);
    nRST = 1'b1;
    clr();
    run(16);
    chk("rst_press_at", first_press, 12);
    chk("rst_press_cnt0", dut_pc[0], 1);
    chk("rst_press_cnt1", dut_pc[1], 1);
    chk("rst_both", both_seen, 1'b1);
    chk("rst_level", LEVEL, 2'b11);
    BIN = 2'b11;
    run(30);

    // clean press then release on ch0
    clr();
    BIN[0] = 1'b0;
    run(40);
    chk("clean_lat", (first_press > 0 && first_press <= 14), 1'b1);
    chk("clean_ch1_silent", dut_pc[1], 0);
    chk("clean_cnt_model", dut_pc[0], mod_pc[0]);
`ifndef AUTO_REPEAT_EN
    chk("clean_cnt0", dut_pc[0], 1);
`endif
    chk("clean_level", LEVEL, 2'b01);
    clr();
    BIN[0] = 1'b1;
    run(40);
    chk("clean_rel_cnt", dut_rc[0], 1);
    chk("clean_rel_level", LEVEL, 2'b00);

    // bounce rejection
    clr();
    for (int t = 0; t < 12; t++) begin
      BIN[0] = ~BIN[0];
      run(5);
    end
    chk("bounce_press", dut_pc[0], 0);
    chk("bounce_rel", dut_rc[0], 0);
    chk("bounce_level", LEVEL, 2'b00);
    clr();
    BIN[0] = 1'b0;
    run(40);
    chk("bounce_hold_model", dut_pc[0], mod_pc[0]);
`ifndef AUTO_REPEAT_EN
    chk("bounce_hold_cnt", dut_pc[0], 1);
`endif
    BIN = 2'b11;
    run(40);

    // simultaneous channels and tick period
    clr();
    BIN = 2'b00;
    run(30);
    chk("simul_both", both_seen, 1'b1);
    k = 0;
    while (!TICK && k < 10) begin
      cycle();
      k++;
    end
    chk("tick_wait", (k < 10), 1'b1);
    p = 0;
    do begin
      cycle();
      p++;
    end while (!TICK && p < 10);
    chk("tick_period", p, 4);
    BIN = 2'b11;
    run(40);

    // reset after two agreeing ticks on ch0
    clr();
    BIN[0] = 1'b0;
    k = 0;
    while (!(tk - last_blk[0] == 2 && m_level[0] == 1'b0) && k < 40) begin
      cycle();
      k++;
    end
    chk("mid_wait", (k < 40), 1'b1);
    chk("mid_no_press", dut_pc[0], 0);
    nRST = 1'b0;
    cycle();
    nRST = 1'b1;
    clr();
    run(16);
    chk("mid_press_at", first_press, 12);
    chk("mid_press_cnt", dut_pc[0], 1);
    BIN = 2'b11;
    run(40);

    // long hold: auto-repeat behaviour, then silence after release
    clr();
    BIN[0] = 1'b0;
    run(100);
    chk("hold_cnt_model", dut_pc[0], mod_pc[0]);
`ifdef AUTO_REPEAT_EN
    chk("hold_repeats", (dut_pc[0] >= 10), 1'b1);
`else
    chk("hold_cnt", dut_pc[0], 1);
`endif
    BIN[0] = 1'b1;
    k = 0;
    while (!RELEASE[0] && k < 40) begin
      cycle();
      k++;
    end
    chk("rel_wait", (k < 40), 1'b1);
    clr();
    run(40);
    chk("post_rel_press", dut_pc[0], 0);

    // randomized segments with occasional resets
    for (int seg = 0; seg < 40; seg++) begin
      BIN = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        nRST = 1'b0;
        cycle();
        nRST = 1'b1;
      end
      run($urandom_range(1, 20));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
